beta_control_unit: RTL and testbench
====================================

Name: beta_control_unit

Overview:
- Instruction-decode control unit for the 32-bit Beta-style datapath.
- Decodes opcode instruction[31:26] into the datapath mux selects, ALU function, memory strobes and register-file write enable.
- Decode is combinational. One clocked register holds a pending-interrupt flag, so interrupts are taken between instructions.
- Sits between the instruction memory output and the PC/regfile/ALU/data-memory muxes.

Parameters:
- none

Ports:
- clk  input  1  system clock; only the interrupt flag is clocked
- rst_n  input  1  asynchronous active-low reset
- instruction  input  32  current instruction; only bits [31:26] are decoded
- z  input  1  1 when register-file read port 1 (Ra) equals zero; used by BEQ/BNE
- irq  input  1  external interrupt request, level-sensitive
- supervisor  input  1  1 when PC[31] is set; interrupts are masked while high
- ALUFN  output  6  ALU function code
- ASEL  output  1  ALU A source: 0 = Ra, 1 = branch offset (PC+4+4*SXT(literal))
- BSEL  output  1  ALU B source: 0 = Rb, 1 = sign-extended literal
- MOE  output  1  data-memory output enable
- MWR  output  1  data-memory write strobe
- PCSEL  output  3  next-PC select: 000 = PC+4, 001 = branch, 010 = JMP, 011 = illegal-op vector, 100 = interrupt vector
- RA2SEL  output  1  regfile port 2 address: 0 = Rb, 1 = Rc
- WASEL  output  1  write address: 0 = Rc, 1 = XP (R30)
- WDSEL  output  2  write data: 00 = PC+4, 01 = ALU, 10 = memory
- WERF  output  1  register-file write enable

Behaviour:
- Default for all decoded cases: ALUFN=000000, ASEL=0, BSEL=0, MOE=0, MWR=0, PCSEL=000, RA2SEL=0, WASEL=0, WDSEL=01, WERF=0. No output is ever X.
- OP class, opcode 10xxxx:
  - ALUFN={2'b10, op[29:26]}.
  - BSEL=0, WDSEL=01, WERF=1.
- OPC class, opcode 11xxxx: same as OP class but BSEL=1.
- LD, 011000: ALUFN=100000, BSEL=1, MOE=1, WDSEL=10, WERF=1.
- ST, 011001: ALUFN=100000, BSEL=1, RA2SEL=1, MWR=1, WERF=0.
- JMP, 011011: PCSEL=010, WDSEL=00, WERF=1.
- BEQ, 011100: PCSEL = z ? 001 : 000; WDSEL=00, WERF=1.
- BNE, 011101: PCSEL = z ? 000 : 001; WDSEL=00, WERF=1.
- LDR, 011111: ALUFN=011010 (pass A), ASEL=1, MOE=1, WDSEL=10, WERF=1.
- Illegal opcode (any other value):
  - PCSEL=011, WASEL=1, WDSEL=00, WERF=1, MWR=0.
  - ALUFN, BSEL and RA2SEL take their default values.
- Interrupt flag irq_pending:
  - Cleared asynchronously while rst_n=0.
  - Set on the rising clk edge when irq=1 and supervisor=0.
  - Cleared on the rising clk edge when the interrupt is taken.
  - A set request on the same edge as the take is ignored; the request is re-sampled afterwards.
- Interrupt take: when irq_pending=1 and supervisor=0, these outputs override decode:
  - PCSEL=100, WASEL=1, WDSEL=00, WERF=1, MWR=0, MOE=0.
  - Takes priority over illegal-op and branch decode.
- Reset (rst_n=0), asynchronous: outputs forced to MWR=0, WERF=0, PCSEL=000, MOE=0. Other outputs follow decode.
- Latency: all outputs are combinational from instruction, z, supervisor, irq_pending and rst_n. Zero cycles.

Test Plan:
- rst_n=1, no irq, instruction[31:26]=100000 (ADD) -> ALUFN=100000, ASEL=0, BSEL=0, MWR=0, PCSEL=000, RA2SEL=0, WASEL=0, WDSEL=01, WERF=1, MOE=0.
- instruction[31:26]=110001 (SUBC) -> ALUFN=100001, BSEL=1, WDSEL=01, WERF=1, PCSEL=000.
- instruction[31:26]=011000 (LD) -> ALUFN=100000, ASEL=0, BSEL=1, MOE=1, MWR=0, WDSEL=10, WERF=1, PCSEL=000.
- ST (011001) -> MWR=1, RA2SEL=1, WERF=0.
- BEQ (011100): z=1 -> PCSEL=001; z=0 -> PCSEL=000.
- BNE (011101): z=1 -> PCSEL=000; z=0 -> PCSEL=001.
- JMP (011011) -> PCSEL=010, WDSEL=00, WERF=1.
- Opcode 000000 -> PCSEL=011, WASEL=1, WDSEL=00, WERF=1.
- Interrupt:
  - Assert irq with supervisor=0 for one clk edge -> PCSEL=100, WASEL=1, WERF=1.
  - Next edge with irq=0 -> flag clears and normal decode returns.
  - Repeat with supervisor=1 -> no interrupt taken.
- Pull rst_n low mid-cycle with ST decoded and a pending irq -> MWR=0, WERF=0, PCSEL=000 immediately, and irq_pending clears.

Source files
------------

// File: rtl/beta_control_unit.sv
// ----------------------------------------------------------------------------
// beta_control_unit
// Instruction-decode control unit for a 32-bit Beta-style datapath.
// Opcode instruction[31:26] is decoded combinationally into mux selects, the
// ALU function, memory strobes and the register-file write enable. A single
// clocked flag remembers a pending interrupt so it is taken between
// instructions. Interrupt take overrides decode; reset overrides everything
// that could disturb architectural state (memory write, regfile write, PC).
// ----------------------------------------------------------------------------
module beta_control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        z,
    input  logic        irq,
    input  logic        supervisor,
    output logic [5:0]  ALUFN,
    output logic        ASEL,
    output logic        BSEL,
    output logic        MOE,
    output logic        MWR,
    output logic [2:0]  PCSEL,
    output logic        RA2SEL,
    output logic        WASEL,
    output logic [1:0]  WDSEL,
    output logic        WERF
);

    // Opcodes of the memory / control-transfer group
    localparam logic [5:0] OPC_LD  = 6'b011000;
    localparam logic [5:0] OPC_ST  = 6'b011001;
    localparam logic [5:0] OPC_JMP = 6'b011011;
    localparam logic [5:0] OPC_BEQ = 6'b011100;
    localparam logic [5:0] OPC_BNE = 6'b011101;
    localparam logic [5:0] OPC_LDR = 6'b011111;

    // ALU function codes used outside the arithmetic classes
    localparam logic [5:0] ALU_ADD   = 6'b100000;
    localparam logic [5:0] ALU_PASSA = 6'b011010;

    // Next-PC select encodings
    localparam logic [2:0] PC_INC  = 3'b000;
    localparam logic [2:0] PC_BR   = 3'b001;
    localparam logic [2:0] PC_JMP  = 3'b010;
    localparam logic [2:0] PC_ILOP = 3'b011;
    localparam logic [2:0] PC_IRQ  = 3'b100;

    // Write-data select encodings
    localparam logic [1:0] WD_PC  = 2'b00;
    localparam logic [1:0] WD_ALU = 2'b01;
    localparam logic [1:0] WD_MEM = 2'b10;

    logic [5:0] opcode_s;
    logic       unused_instr_s;

    // Decoded (pre-override) control values
    logic [5:0] dec_alufn_s;
    logic       dec_asel_s;
    logic       dec_bsel_s;
    logic       dec_moe_s;
    logic       dec_mwr_s;
    logic [2:0] dec_pcsel_s;
    logic       dec_ra2sel_s;
    logic       dec_wasel_s;
    logic [1:0] dec_wdsel_s;
    logic       dec_werf_s;

    // Interrupt flag
    logic       irq_pending_q;
    logic       irq_pending_d;
    logic       irq_take_s;

    assign opcode_s = instruction[31:26];
    // Literal / register fields are consumed by the datapath, not here
    assign unused_instr_s = ^instruction[25:0];

    // An interrupt is taken whenever one is pending and we are in user mode
    assign irq_take_s = irq_pending_q & ~supervisor;

    // Opcode decode into datapath controls
    always_comb begin
        dec_alufn_s  = 6'b000000;
        dec_asel_s   = 1'b0;
        dec_bsel_s   = 1'b0;
        dec_moe_s    = 1'b0;
        dec_mwr_s    = 1'b0;
        dec_pcsel_s  = PC_INC;
        dec_ra2sel_s = 1'b0;
        dec_wasel_s  = 1'b0;
        dec_wdsel_s  = WD_ALU;
        dec_werf_s   = 1'b0;
        casez (opcode_s)
            6'b1?????: begin
                // OP (register B) and OPC (literal B) share the ALU encoding
                dec_alufn_s = {2'b10, opcode_s[3:0]};
                dec_bsel_s  = opcode_s[4];
                dec_wdsel_s = WD_ALU;
                dec_werf_s  = 1'b1;
            end
            OPC_LD: begin
                dec_alufn_s = ALU_ADD;
                dec_bsel_s  = 1'b1;
                dec_moe_s   = 1'b1;
                dec_wdsel_s = WD_MEM;
                dec_werf_s  = 1'b1;
            end
            OPC_ST: begin
                dec_alufn_s  = ALU_ADD;
                dec_bsel_s   = 1'b1;
                dec_ra2sel_s = 1'b1;
                dec_mwr_s    = 1'b1;
                dec_werf_s   = 1'b0;
            end
            OPC_JMP: begin
                dec_pcsel_s = PC_JMP;
                dec_wdsel_s = WD_PC;
                dec_werf_s  = 1'b1;
            end
            OPC_BEQ: begin
                dec_pcsel_s = z ? PC_BR : PC_INC;
                dec_wdsel_s = WD_PC;
                dec_werf_s  = 1'b1;
            end
            OPC_BNE: begin
                dec_pcsel_s = z ? PC_INC : PC_BR;
                dec_wdsel_s = WD_PC;
                dec_werf_s  = 1'b1;
            end
            OPC_LDR: begin
                dec_alufn_s = ALU_PASSA;
                dec_asel_s  = 1'b1;
                dec_moe_s   = 1'b1;
                dec_wdsel_s = WD_MEM;
                dec_werf_s  = 1'b1;
            end
            default: begin
                // Illegal opcode: trap to the illegal-op vector, save PC+4 in XP
                dec_pcsel_s = PC_ILOP;
                dec_wasel_s = 1'b1;
                dec_wdsel_s = WD_PC;
                dec_werf_s  = 1'b1;
                dec_mwr_s   = 1'b0;
            end
        endcase
    end

    // Apply interrupt-take override, then the reset safety override
    always_comb begin
        ALUFN  = dec_alufn_s;
        ASEL   = dec_asel_s;
        BSEL   = dec_bsel_s;
        MOE    = dec_moe_s;
        MWR    = dec_mwr_s;
        PCSEL  = dec_pcsel_s;
        RA2SEL = dec_ra2sel_s;
        WASEL  = dec_wasel_s;
        WDSEL  = dec_wdsel_s;
        WERF   = dec_werf_s;
        if (irq_take_s) begin
            PCSEL = PC_IRQ;
            WASEL = 1'b1;
            WDSEL = WD_PC;
            WERF  = 1'b1;
            MWR   = 1'b0;
            MOE   = 1'b0;
        end else begin
            PCSEL = PCSEL;
        end
        if (!rst_n) begin
            // Reset acts immediately, without waiting for a clock edge
            MWR   = 1'b0;
            WERF  = 1'b0;
            PCSEL = PC_INC;
            MOE   = 1'b0;
        end else begin
            WERF = WERF;
        end
    end

    // Next state of the pending-interrupt flag; a take wins over a new request
    always_comb begin
        irq_pending_d = irq_pending_q;
        if (irq_take_s) begin
            irq_pending_d = 1'b0;
        end else if (irq && !supervisor) begin
            irq_pending_d = 1'b1;
        end else begin
            irq_pending_d = irq_pending_q;
        end
    end

    // Pending-interrupt flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_pending_q <= 1'b0;
        end else begin
            irq_pending_q <= irq_pending_d;
        end
    end

endmodule

// File: tb/tb_beta_control_unit.sv
// ----------------------------------------------------------------------------
// tb_beta_control_unit
// Directed plus randomized stimulus, compared against a behavioural model of
// the control unit built from the opcode table and the interrupt rules.
// ----------------------------------------------------------------------------
module tb_beta_control_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        z;
    logic        irq;
    logic        supervisor;
    logic [5:0]  ALUFN;
    logic        ASEL;
    logic        BSEL;
    logic        MOE;
    logic        MWR;
    logic [2:0]  PCSEL;
    logic        RA2SEL;
    logic        WASEL;
    logic [1:0]  WDSEL;
    logic        WERF;

    int n_cmp;
    int n_mis;

    logic model_pending;

    beta_control_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .z           (z),
        .irq         (irq),
        .supervisor  (supervisor),
        .ALUFN       (ALUFN),
        .ASEL        (ASEL),
        .BSEL        (BSEL),
        .MOE         (MOE),
        .MWR         (MWR),
        .PCSEL       (PCSEL),
        .RA2SEL      (RA2SEL),
        .WASEL       (WASEL),
        .WDSEL       (WDSEL),
        .WERF        (WERF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bundle of all outputs: {ALUFN,ASEL,BSEL,MOE,MWR,PCSEL,RA2SEL,WASEL,WDSEL,WERF}
    logic [17:0] obs_s;
    assign obs_s = {ALUFN, ASEL, BSEL, MOE, MWR, PCSEL, RA2SEL, WASEL, WDSEL, WERF};

    // Reference interrupt flag: set by a user-mode request, cleared by a take
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            model_pending <= 1'b0;
        else if (model_pending && !supervisor)
            model_pending <= 1'b0;
        else if (irq && !supervisor)
            model_pending <= 1'b1;
    end

    // Expected outputs from the opcode table and override rules
    function automatic logic [17:0] ref_out(input logic [5:0] op, input logic zz,
                                           input logic sup, input logic pend,
                                           input logic rstn);
        logic [5:0] alufn;
        logic       asel, bsel, moe, mwr, ra2, wasel, werf;
        logic [2:0] pcsel;
        logic [1:0] wdsel;
        alufn = 6'd0; asel = 1'b0; bsel = 1'b0; moe = 1'b0; mwr = 1'b0;
        pcsel = 3'd0; ra2 = 1'b0; wasel = 1'b0; wdsel = 2'd1; werf = 1'b0;
        if (op >= 6'd32) begin
            alufn = 6'd32 + (op % 6'd16);
            bsel  = (op >= 6'd48);
            werf  = 1'b1;
        end else if (op == 6'd24) begin            // LD
            alufn = 6'd32; bsel = 1'b1; moe = 1'b1; wdsel = 2'd2; werf = 1'b1;
        end else if (op == 6'd25) begin            // ST
            alufn = 6'd32; bsel = 1'b1; ra2 = 1'b1; mwr = 1'b1;
        end else if (op == 6'd27) begin            // JMP
            pcsel = 3'd2; wdsel = 2'd0; werf = 1'b1;
        end else if (op == 6'd28 || op == 6'd29) begin  // BEQ / BNE
            pcsel = ((op == 6'd28) == (zz == 1'b1)) ? 3'd1 : 3'd0;
            wdsel = 2'd0; werf = 1'b1;
        end else if (op == 6'd31) begin            // LDR
            alufn = 6'd26; asel = 1'b1; moe = 1'b1; wdsel = 2'd2; werf = 1'b1;
        end else begin                             // illegal
            pcsel = 3'd3; wasel = 1'b1; wdsel = 2'd0; werf = 1'b1;
        end
        if (pend && !sup) begin
            pcsel = 3'd4; wasel = 1'b1; wdsel = 2'd0; werf = 1'b1; mwr = 1'b0; moe = 1'b0;
        end
        if (!rstn) begin
            mwr = 1'b0; werf = 1'b0; pcsel = 3'd0; moe = 1'b0;
        end
        return {alufn, asel, bsel, moe, mwr, pcsel, ra2, wasel, wdsel, werf};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive just after the edge, compare mid-cycle against the model
    task automatic step(input string tag, input logic [5:0] op, input logic zz,
                        input logic irqv, input logic supv);
        logic [25:0] low;
        @(posedge clk);
        #1;
        low         = 26'($urandom());
        instruction = {op, low};
        z           = zz;
        irq         = irqv;
        supervisor  = supv;
        #3;
        check(tag, 32'(obs_s), 32'(ref_out(op, zz, supv, model_pending, rst_n)));
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b0;
        instruction = {6'b011001, 26'd0};   // ST under reset
        z = 1'b0; irq = 1'b0; supervisor = 1'b0;
        #2;
        check("reset_mwr",   32'(MWR),   32'd0);
        check("reset_werf",  32'(WERF),  32'd0);
        check("reset_pcsel", 32'(PCSEL), 32'd0);
        check("reset_moe",   32'(MOE),   32'd0);
        #11 rst_n = 1'b1;

        // Directed decode checks against table literals
        step("add", 6'b100000, 1'b0, 1'b0, 1'b0);
        check("add_lit", 32'(obs_s), 32'(18'b100000_0_0_0_0_000_0_0_01_1));
        step("subc", 6'b110001, 1'b0, 1'b0, 1'b0);
        check("subc_lit", 32'(obs_s), 32'(18'b100001_0_1_0_0_000_0_0_01_1));
        step("ld", 6'b011000, 1'b0, 1'b0, 1'b0);
        check("ld_lit", 32'(obs_s), 32'(18'b100000_0_1_1_0_000_0_0_10_1));
        step("st", 6'b011001, 1'b0, 1'b0, 1'b0);
        check("st_lit", 32'(obs_s), 32'(18'b100000_0_1_0_1_000_1_0_01_0));
        step("beq_z1", 6'b011100, 1'b1, 1'b0, 1'b0);
        check("beq_z1_pcsel", 32'(PCSEL), 32'd1);
        step("beq_z0", 6'b011100, 1'b0, 1'b0, 1'b0);
        check("beq_z0_pcsel", 32'(PCSEL), 32'd0);
        step("bne_z1", 6'b011101, 1'b1, 1'b0, 1'b0);
        check("bne_z1_pcsel", 32'(PCSEL), 32'd0);
        step("bne_z0", 6'b011101, 1'b0, 1'b0, 1'b0);
        check("bne_z0_pcsel", 32'(PCSEL), 32'd1);
        step("jmp", 6'b011011, 1'b0, 1'b0, 1'b0);
        check("jmp_lit", 32'(obs_s), 32'(18'b000000_0_0_0_0_010_0_0_00_1));
        step("ldr", 6'b011111, 1'b0, 1'b0, 1'b0);
        check("ldr_lit", 32'(obs_s), 32'(18'b011010_1_0_1_0_000_0_0_10_1));
        step("illop", 6'b000000, 1'b0, 1'b0, 1'b0);
        check("illop_lit", 32'(obs_s), 32'(18'b000000_0_0_0_0_011_0_1_00_1));

        // Interrupt in user mode: request, take, then clear
        step("irq_req", 6'b100000, 1'b0, 1'b1, 1'b0);
        check("irq_req_pcsel", 32'(PCSEL), 32'd0);
        step("irq_take", 6'b100000, 1'b0, 1'b0, 1'b0);
        check("irq_take_lit", 32'(obs_s), 32'(18'b100000_0_0_0_0_100_0_1_00_1));
        step("irq_clear", 6'b100000, 1'b0, 1'b0, 1'b0);
        check("irq_clear_pcsel", 32'(PCSEL), 32'd0);

        // Supervisor mode masks the request entirely
        step("sup_req", 6'b100000, 1'b0, 1'b1, 1'b1);
        step("sup_hold", 6'b100000, 1'b0, 1'b0, 1'b1);
        step("sup_user", 6'b100000, 1'b0, 1'b0, 1'b0);
        check("sup_no_take", 32'(PCSEL), 32'd0);

        // Pending irq held in supervisor mode with ST decoded, then reset mid-cycle
        step("pend_set", 6'b011001, 1'b0, 1'b1, 1'b0);
        step("pend_st", 6'b011001, 1'b0, 1'b0, 1'b1);
        check("pend_st_mwr", 32'(MWR), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mwr",   32'(MWR),   32'd0);
        check("mid_rst_werf",  32'(WERF),  32'd0);
        check("mid_rst_pcsel", 32'(PCSEL), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        supervisor = 1'b0;
        #1;
        check("mid_rst_flag_clear", 32'(PCSEL), 32'd0);

        // Randomized stimulus against the model
        for (int i = 0; i < 2000; i++) begin
            logic [5:0] op;
            logic       zz, iq, sp;
            if ($urandom_range(0, 3) == 0)
                op = 6'($urandom());
            else
                case ($urandom_range(0, 7))
                    0: op = 6'b011000;
                    1: op = 6'b011001;
                    2: op = 6'b011011;
                    3: op = 6'b011100;
                    4: op = 6'b011101;
                    5: op = 6'b011111;
                    6: op = 6'b011010;
                    default: op = 6'($urandom_range(32, 63));
                endcase
            zz = 1'($urandom());
            iq = ($urandom_range(0, 4) == 0);
            sp = ($urandom_range(0, 3) == 0);
            step("rand", op, zz, iq, sp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
